// File: rtl/log2_fp_pkg.sv
// rtl/log2_fp_pkg.sv - shared parameters, state encoding and result type for the log2 datapath
package log2_fp_pkg;

  localparam int IN_W_DEF   = 32;
  localparam int FRAC_W_DEF = 16;
  localparam int MANT_W_DEF = 16;
  localparam int INT_W_DEF  = $clog2(IN_W_DEF);

  // Sequencer states of the fractional-log2 iterator
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Unsigned fixed-point log2 result: integer part above FRAC_W fraction bits
  typedef struct packed {
    logic [INT_W_DEF-1:0]  int_part;
    logic [FRAC_W_DEF-1:0] frac;
  } log2_res_t;

endpackage

// File: rtl/log2_frac_step.sv
// rtl/log2_frac_step.sv - one squaring step producing a single fractional log2 bit
module log2_frac_step
  import log2_fp_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF
) (
  input  logic [MANT_W-1:0] mant_i,
  output logic [MANT_W-1:0] mant_o,
  output logic              frac_bit_o
);

  logic [2*MANT_W-1:0] sq;
  logic                unused_sq_lsb;

  // Square the 1.x mantissa; a product >= 2 yields a 1 bit and renormalizes by one place
  always_comb begin
    sq         = {{MANT_W{1'b0}}, mant_i} * {{MANT_W{1'b0}}, mant_i};
    frac_bit_o = sq[2*MANT_W-1];
    if (frac_bit_o) begin
      mant_o = sq[2*MANT_W-1 -: MANT_W];
    end else begin
      mant_o = sq[2*MANT_W-2 -: MANT_W];
    end
  end

  // Low product bits fall below the mantissa's precision and are truncated
  assign unused_sq_lsb = ^sq[MANT_W-2:0];

endmodule

// File: rtl/log2_frac_iter.sv
// rtl/log2_frac_iter.sv - normalizes an operand by its clz and iterates fractional log2 bits
module log2_frac_iter
  import log2_fp_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int MANT_W = MANT_W_DEF,
  localparam int INT_W = $clog2(IN_W)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enb,
  input  logic [IN_W-1:0]         i_WORD,
  input  logic [7:0]              i_CLZ,
  input  logic                    i_VALID,
  output logic                    o_READY,
  output logic [INT_W+FRAC_W-1:0] o_LOG2,
  output logic                    o_ZERO,
  output logic                    o_VALID,
  input  logic                    i_READY
);

  localparam int CNT_W = $clog2(FRAC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAC_W - 1);

  state_e                    state_q;
  logic [IN_W-1:0]           word_q;
  logic [7:0]                clz_q;
  logic [MANT_W-1:0]         mant_q;
  logic [INT_W-1:0]          int_q;
  logic                      zero_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [FRAC_W-1:0]         frac_q;
  logic                      ready_q;
  logic                      valid_q;
  logic [INT_W+FRAC_W-1:0]   log2_q;
  logic                      zero_out_q;

  logic [IN_W-1:0]           sh_d;
  logic [MANT_W-1:0]         mant_norm_d;
  logic [INT_W-1:0]          int_norm_d;
  logic                      zero_norm_d;
  logic [MANT_W-1:0]         step_mant;
  logic                      step_bit;
  logic [FRAC_W-1:0]         frac_d;
  logic                      unused_sh_lsb;

  // Normalization of the captured operand; shifts of IN_W or more clear the word
  always_comb begin
    sh_d        = word_q << clz_q;
    mant_norm_d = sh_d[IN_W-1 -: MANT_W];
    int_norm_d  = INT_W'(IN_W - 1) - clz_q[INT_W-1:0];
    zero_norm_d = (clz_q >= 8'(IN_W));
    frac_d      = {frac_q[FRAC_W-2:0], step_bit};
  end

  assign unused_sh_lsb = ^sh_d[IN_W-MANT_W-1:0];

  log2_frac_step #(
    .MANT_W (MANT_W)
  ) u_step (
    .mant_i     (mant_q),
    .mant_o     (step_mant),
    .frac_bit_o (step_bit)
  );

  // Sequencer IDLE -> NORM -> ITER (FRAC_W cycles) -> DONE with registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      clz_q      <= '0;
      mant_q     <= '0;
      int_q      <= '0;
      zero_q     <= 1'b0;
      cnt_q      <= '0;
      frac_q     <= '0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      log2_q     <= '0;
      zero_out_q <= 1'b0;
    end else if (enb) begin
      case (state_q)
        ST_IDLE: begin
          if (i_VALID && ready_q) begin
            word_q  <= i_WORD;
            clz_q   <= i_CLZ;
            ready_q <= 1'b0;
            state_q <= ST_NORM;
          end
        end
        ST_NORM: begin
          mant_q  <= mant_norm_d;
          int_q   <= int_norm_d;
          zero_q  <= zero_norm_d;
          cnt_q   <= '0;
          frac_q  <= '0;
          state_q <= ST_ITER;
        end
        ST_ITER: begin
          mant_q <= step_mant;
          frac_q <= frac_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            log2_q     <= zero_q ? '0 : {int_q, frac_d};
            zero_out_q <= zero_q;
            valid_q    <= 1'b1;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_READY) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_READY = ready_q;
  assign o_VALID = valid_q;
  assign o_LOG2  = log2_q;
  assign o_ZERO  = zero_out_q;

endmodule

// File: tb/tb_log2_frac_iter.sv
// tb/tb_log2_frac_iter.sv - directed and table-driven checks of the fractional log2 iterator
module tb_log2_frac_iter;
  import log2_fp_pkg::*;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  clz;
    logic        use_model;
    logic [20:0] exp_log2;
    logic        exp_zero;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enb;
  logic [31:0] i_WORD;
  logic [7:0]  i_CLZ;
  logic        i_VALID;
  logic        o_READY;
  logic [20:0] o_LOG2;
  logic        o_ZERO;
  logic        o_VALID;
  logic        i_READY;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  log2_frac_iter dut (
    .clk     (clk),
    .reset   (reset),
    .enb     (enb),
    .i_WORD  (i_WORD),
    .i_CLZ   (i_CLZ),
    .i_VALID (i_VALID),
    .o_READY (o_READY),
    .o_LOG2  (o_LOG2),
    .o_ZERO  (o_ZERO),
    .o_VALID (o_VALID),
    .i_READY (i_READY)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] count_lz(input logic [31:0] w);
    logic [7:0] n;
    n = 8'd32;
    for (int i = 31; i >= 0; i--) begin
      if (w[i]) begin
        n = 8'(31 - i);
        break;
      end
    end
    return n;
  endfunction

  // Reference: integer arithmetic version of normalize + repeated squaring
  function automatic logic [20:0] model_log2(input logic [31:0] w, input logic [7:0] c);
    logic [63:0] m;
    logic [63:0] sq;
    logic [15:0] frac;
    logic [4:0]  ip;
    if (c >= 8'd32) return 21'd0;
    m    = (({32'd0, w} << c) & 64'hFFFF_FFFF) >> 16;
    frac = 16'd0;
    for (int k = 0; k < 16; k++) begin
      sq = m * m;
      if (sq >= 64'h8000_0000) begin
        frac = {frac[14:0], 1'b1};
        m    = sq >> 16;
      end else begin
        frac = {frac[14:0], 1'b0};
        m    = sq >> 15;
      end
    end
    ip = 5'd31 - c[4:0];
    return {ip, frac};
  endfunction

  // One transaction; optional enable stall during ITER and optional hold in DONE
  task automatic run_op(input logic [31:0] w, input logic [7:0] c, input int stall_at,
                        input int stall_len, input int hold,
                        output logic [20:0] res, output logic zr, output int lat);
    check("ready_before_accept", {31'd0, o_READY}, 32'd1);
    i_WORD  = w;
    i_CLZ   = c;
    i_VALID = 1'b1;
    @(posedge clk); #1;
    lat     = 1;
    i_VALID = 1'b0;
    while (!o_VALID && lat < 200) begin
      if (lat == stall_at) enb = 1'b0;
      if (lat == stall_at + stall_len) enb = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    enb = 1'b1;
    check("valid_within_bound", {31'd0, o_VALID}, 32'd1);
    res = o_LOG2;
    zr  = o_ZERO;
    for (int h = 0; h < hold; h++) begin
      i_VALID = 1'b1;
      i_WORD  = 32'h0000_DEAD;
      i_CLZ   = 8'd16;
      @(posedge clk); #1;
      check("hold_valid", {31'd0, o_VALID}, 32'd1);
      check("hold_log2", {11'd0, o_LOG2}, {11'd0, res});
      check("hold_zero", {31'd0, o_ZERO}, {31'd0, zr});
      check("hold_ready", {31'd0, o_READY}, 32'd0);
    end
    i_VALID = 1'b0;
    i_READY = 1'b1;
    @(posedge clk); #1;
    i_READY = 1'b0;
    check("ready_after_ack", {31'd0, o_READY}, 32'd1);
    check("valid_after_ack", {31'd0, o_VALID}, 32'd0);
  endtask

  initial begin
    vec_t        vecs[$];
    logic [20:0] res;
    logic [20:0] exp;
    logic        zr;
    int          lat;
    logic [31:0] w;
    logic [7:0]  c;

    reset   = 1'b1;
    enb     = 1'b1;
    i_WORD  = '0;
    i_CLZ   = '0;
    i_VALID = 1'b0;
    i_READY = 1'b0;

    vecs.push_back('{32'h0000_0001, 8'd31, 1'b0, 21'h000000, 1'b0});
    vecs.push_back('{32'h8000_0000, 8'd0,  1'b0, 21'h1F0000, 1'b0});
    vecs.push_back('{32'h0000_0000, 8'd32, 1'b0, 21'h000000, 1'b1});
    vecs.push_back('{32'h0001_0000, 8'd15, 1'b0, 21'h100000, 1'b0});
    vecs.push_back('{32'h0000_0002, 8'd30, 1'b0, 21'h010000, 1'b0});
    vecs.push_back('{32'h4000_0000, 8'd1,  1'b0, 21'h1E0000, 1'b0});
    vecs.push_back('{32'h0000_0005, 8'd40, 1'b0, 21'h000000, 1'b1});
    vecs.push_back('{32'h0000_0003, 8'd30, 1'b1, 21'h000000, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 8'd0,  1'b1, 21'h000000, 1'b0});
    vecs.push_back('{32'h0000_00FF, 8'd24, 1'b1, 21'h000000, 1'b0});

    #13;
    check("reset_ready", {31'd0, o_READY}, 32'd1);
    check("reset_valid", {31'd0, o_VALID}, 32'd0);
    check("reset_log2", {11'd0, o_LOG2}, 32'd0);
    check("reset_zero", {31'd0, o_ZERO}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].word, vecs[i].clz, -1, 0, 0, res, zr, lat);
      exp = vecs[i].use_model ? model_log2(vecs[i].word, vecs[i].clz) : vecs[i].exp_log2;
      check($sformatf("vec%0d_log2", i), {11'd0, res}, {11'd0, exp});
      check($sformatf("vec%0d_zero", i), {31'd0, zr}, {31'd0, vecs[i].exp_zero});
      check($sformatf("vec%0d_latency", i), lat, 32'd18);
    end

    // log2(1.5) truncated must sit just under 0x95C0
    run_op(32'd3, 8'd30, -1, 0, 0, res, zr, lat);
    check("log2_1p5_upper", {31'd0, (res[15:0] <= 16'h95C0)}, 32'd1);
    check("log2_1p5_lower", {31'd0, (res[15:0] >= 16'h9580)}, 32'd1);
    check("log2_1p5_int", {27'd0, res[20:16]}, 32'd1);

    // DONE hold with i_READY low and stray i_VALID ignored
    run_op(32'h0001_2345, 8'd15, -1, 0, 5, res, zr, lat);
    check("hold_op_log2", {11'd0, res}, {11'd0, model_log2(32'h0001_2345, 8'd15)});
    run_op(32'h0000_0007, 8'd29, -1, 0, 0, res, zr, lat);
    check("after_hold_log2", {11'd0, res}, {11'd0, model_log2(32'h0000_0007, 8'd29)});

    // Enable stall of 3 cycles mid-ITER
    run_op(32'h00AB_CDEF, 8'd8, 5, 3, 0, res, zr, lat);
    check("stall_latency", lat, 32'd21);
    check("stall_log2", {11'd0, res}, {11'd0, model_log2(32'h00AB_CDEF, 8'd8)});

    // Reset during ITER with cnt=7; previous result left o_LOG2 nonzero
    run_op(32'h8000_0000, 8'd0, -1, 0, 0, res, zr, lat);
    check("pre_reset_log2", {11'd0, o_LOG2}, 32'h001F_0000);
    i_WORD  = 32'd3;
    i_CLZ   = 8'd30;
    i_VALID = 1'b1;
    @(posedge clk); #1;
    i_VALID = 1'b0;
    for (int k = 1; k < 9; k++) begin
      @(posedge clk); #1;
    end
    check("pre_reset_busy", {31'd0, o_READY}, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("midop_reset_ready", {31'd0, o_READY}, 32'd1);
    check("midop_reset_valid", {31'd0, o_VALID}, 32'd0);
    check("midop_reset_log2", {11'd0, o_LOG2}, 32'd0);
    check("midop_reset_zero", {31'd0, o_ZERO}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_op(32'h0000_0003, 8'd30, -1, 0, 0, res, zr, lat);
    check("post_reset_log2", {11'd0, res}, {11'd0, model_log2(32'd3, 8'd30)});
    check("post_reset_latency", lat, 32'd18);

    // Random sweep against the reference model
    for (int n = 0; n < 150; n++) begin
      w = $urandom >> $urandom_range(0, 31);
      if (n % 37 == 0) w = 32'd0;
      c = count_lz(w);
      run_op(w, c, -1, 0, 0, res, zr, lat);
      check($sformatf("rand%0d_log2 w=%0h", n, w), {11'd0, res}, {11'd0, model_log2(w, c)});
      check($sformatf("rand%0d_zero w=%0h", n, w), {31'd0, zr}, {31'd0, (w == 32'd0)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
